// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, ALU ops,
// datapath select codes, FSM state codes and small decode helpers.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;
    localparam logic       SRCB_RS2  = 1'b0;
    localparam logic       SRCB_IMM  = 1'b1;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEM       = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_TRAP      = 3'd6;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR
    } instr_class_t;

    // alt selects SUB/SRA; callers gate it so ADDI/SRLI never see it set wrongly.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_instr_decode.sv
// Combinational RV32I decode of the instruction register fields into
// datapath selects, ALU operation, instruction class and legality.
module rv_instr_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output logic [3:0]   alu_control,
    output logic [2:0]   imm_sel,
    output logic [1:0]   alu_src_a,
    output logic         alu_src_b,
    output instr_class_t instr_class,
    output logic         illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        imm_sel     = IMM_I;
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        instr_class = CLS_ALU;
        illegal     = 1'b0;

        case (opcode)
            OPC_OP: begin
                alu_control = alu_from_funct3(funct3, funct7[5]);
                if (funct7 != F7_BASE &&
                    !(funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
                    illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                alu_src_b   = SRCB_IMM;
                alu_control = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                // Only the shift-immediate forms carry funct7 in the immediate field.
                if (funct3 == 3'b001 && funct7 != F7_BASE)
                    illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
                    illegal = 1'b1;
            end
            OPC_LUI: begin
                imm_sel   = IMM_U;
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            OPC_AUIPC: begin
                imm_sel   = IMM_U;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_IMM;
            end
            OPC_LOAD: begin
                alu_src_b   = SRCB_IMM;
                instr_class = CLS_LOAD;
            end
            OPC_STORE: begin
                imm_sel     = IMM_S;
                alu_src_b   = SRCB_IMM;
                instr_class = CLS_STORE;
            end
            OPC_BRANCH: begin
                imm_sel     = IMM_B;
                alu_control = ALU_SUB;
                instr_class = CLS_BRANCH;
            end
            OPC_JAL: begin
                imm_sel     = IMM_J;
                instr_class = CLS_JAL;
            end
            OPC_JALR: begin
                alu_src_b   = SRCB_IMM;
                instr_class = CLS_JALR;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle RV32I control FSM: owns the instruction register, the memory
// wait/timeout counter and sticky trap flags; outputs are decoded from state+IR.
module multicycle_ctrl_unit
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          RESET_FETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_src,
    output logic [31:0] instr,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [3:0]  alu_control,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        reg_write_en,
    output logic [1:0]  result_src,
    output logic [2:0]  state,
    output logic        illegal_instr,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    logic [2:0]       state_q;
    logic [2:0]       state_next;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal_q;
    logic             timeout_q;

    logic [3:0]   dec_alu_control;
    logic [2:0]   dec_imm_sel;
    logic [1:0]   dec_alu_src_a;
    logic         dec_alu_src_b;
    instr_class_t dec_class;
    logic         dec_illegal;

    logic mem_wait;
    logic timeout_hit;

    rv_instr_decode u_decode (
        .opcode      (ir_q[6:0]),
        .funct3      (ir_q[14:12]),
        .funct7      (ir_q[31:25]),
        .alu_control (dec_alu_control),
        .imm_sel     (dec_imm_sel),
        .alu_src_a   (dec_alu_src_a),
        .alu_src_b   (dec_alu_src_b),
        .instr_class (dec_class),
        .illegal     (dec_illegal)
    );

    assign mem_wait    = (state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready;
    // A ready on the limit cycle is not a wait, so it naturally beats the trap.
    assign timeout_hit = TIMEOUT_EN && mem_wait && (cnt_q == CNT_LAST);

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:
                if (RESET_FETCH || start) state_next = ST_FETCH;
            ST_FETCH:
                if (mem_ready)        state_next = ST_DECODE;
                else if (timeout_hit) state_next = ST_TRAP;
            ST_DECODE:
                state_next = dec_illegal ? ST_TRAP : ST_EXECUTE;
            ST_EXECUTE:
                case (dec_class)
                    CLS_LOAD, CLS_STORE: state_next = ST_MEM;
                    CLS_BRANCH:          state_next = ST_FETCH;
                    default:             state_next = ST_WRITEBACK;
                endcase
            ST_MEM:
                if (mem_ready)        state_next = (dec_class == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
                else if (timeout_hit) state_next = ST_TRAP;
            ST_WRITEBACK:
                state_next = ST_FETCH;
            ST_TRAP:
                state_next = ST_TRAP;
            default:
                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_next;
            if (state_q == ST_FETCH && mem_ready)
                ir_q <= mem_rdata;
            if (state_next != state_q)
                cnt_q <= '0;
            else if (mem_wait && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
            if (state_q == ST_DECODE && dec_illegal)
                illegal_q <= 1'b1;
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_src     = 1'b0;
        imm_sel      = IMM_I;
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_RS2;
        alu_control  = ALU_ADD;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        ir_write     = 1'b0;
        reg_write_en = 1'b0;
        result_src   = RES_ALU;

        case (state_q)
            ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK: begin
                imm_sel     = dec_imm_sel;
                alu_src_a   = dec_alu_src_a;
                alu_src_b   = dec_alu_src_b;
                alu_control = dec_alu_control;
            end
            default: ;
        endcase

        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            ST_EXECUTE: begin
                pc_write = 1'b1;
                case (dec_class)
                    CLS_BRANCH:
                        pc_src = branch_taken(ir_q[14:12], alu_zero, alu_lt, alu_ltu)
                                 ? PC_TARGET : PC_PLUS4;
                    CLS_JAL:  pc_src = PC_TARGET;
                    CLS_JALR: pc_src = PC_JALR;
                    default:  pc_src = PC_PLUS4;
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                mem_we   = (dec_class == CLS_STORE);
            end
            ST_WRITEBACK: begin
                reg_write_en = 1'b1;
                case (dec_class)
                    CLS_LOAD:          result_src = RES_MEM;
                    CLS_JAL, CLS_JALR: result_src = RES_PC4;
                    default:           result_src = RES_ALU;
                endcase
            end
            default: ;
        endcase
    end

    assign instr         = ir_q;
    assign state         = state_q;
    assign illegal_instr = illegal_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: per-stage control expectations are
// queued when an instruction is planned and popped as the FSM walks through it.
module tb_multicycle_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        addr_src;
    logic [31:0] instr;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [3:0]  alu_control;
    logic        alu_zero;
    logic        alu_lt;
    logic        alu_ltu;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        reg_write_en;
    logic [1:0]  result_src;
    logic [2:0]  state;
    logic        illegal_instr;
    logic        timeout_err;

    always #5 clk = ~clk;

    multicycle_ctrl_unit #(.MEM_TIMEOUT(16), .RESET_FETCH(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .instr(instr),
        .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .reg_write_en(reg_write_en), .result_src(result_src), .state(state),
        .illegal_instr(illegal_instr), .timeout_err(timeout_err)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] cv(input logic [2:0] imm, input logic [1:0] sa, input logic sbv,
                                       input logic [3:0] alu, input logic pcw, input logic [1:0] pcs,
                                       input logic rwe, input logic [1:0] rs, input logic req,
                                       input logic we, input logic asrc, input logic [2:0] st);
        return {42'd0, imm, sa, sbv, alu, pcw, pcs, rwe, rs, req, we, asrc, st};
    endfunction

    function automatic logic [63:0] ctrl_now();
        return {42'd0, imm_sel, alu_src_a, alu_src_b, alu_control, pc_write, pc_src,
                reg_write_en, result_src, mem_req, mem_we, addr_src, state};
    endfunction

    function automatic logic [63:0] all_outputs();
        return {7'd0, mem_req, mem_we, addr_src, instr, imm_sel, alu_src_a, alu_src_b,
                alu_control, pc_write, pc_src, ir_write, reg_write_en, result_src, state,
                illegal_instr, timeout_err};
    endfunction

    // Register-writing instruction: DECODE, EXECUTE, WRITEBACK.
    task automatic plan_wb(input logic [31:0] w, input logic [2:0] imm, input logic [1:0] sa,
                           input logic sbv, input logic [3:0] alu, input logic [1:0] pcs,
                           input logic [1:0] rs);
        push("ir", {32'd0, w});
        push($sformatf("%h_dec", w), cv(imm, sa, sbv, alu, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        push($sformatf("%h_exe", w), cv(imm, sa, sbv, alu, 1, pcs, 0, 0, 0, 0, 0, 3'd3));
        push($sformatf("%h_wb", w),  cv(imm, sa, sbv, alu, 0, 0, 1, rs, 0, 0, 0, 3'd5));
    endtask

    task automatic plan_branch(input logic [31:0] w, input logic taken);
        push("ir", {32'd0, w});
        push($sformatf("%h_dec", w), cv(3'd2, 0, 0, 4'd1, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        push($sformatf("%h_exe", w), cv(3'd2, 0, 0, 4'd1, 1, {1'b0, taken}, 0, 0, 0, 0, 0, 3'd3));
    endtask

    task automatic plan_load(input logic [31:0] w);
        push("ir", {32'd0, w});
        push("lw_dec", cv(3'd0, 0, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        push("lw_exe", cv(3'd0, 0, 1, 4'd0, 1, 0, 0, 0, 0, 0, 0, 3'd3));
        push("lw_mem", cv(3'd0, 0, 1, 4'd0, 0, 0, 0, 0, 1, 0, 1, 3'd4));
        push("lw_wb",  cv(3'd0, 0, 1, 4'd0, 0, 0, 1, 2'd1, 0, 0, 0, 3'd5));
    endtask

    // Fetches w, then pops queued expectations one per FSM stage.
    task automatic issue(input logic [31:0] w, input int unsigned fetch_waits,
                         input int unsigned mem_waits);
        exp_t        e;
        int unsigned guard;
        chk("fetch_state", state, 3'd1);
        for (int unsigned i = 0; i < fetch_waits; i++) begin
            chk("fetch_wait", {mem_req, mem_we, addr_src, ir_write}, 4'b1000);
            step();
        end
        mem_ready = 1'b1;
        mem_rdata = w;
        #1;
        chk("fetch_ir_write", {mem_req, ir_write}, 2'b11);
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
        guard = 0;
        while (sb.size() > 0 && guard < 32) begin
            guard++;
            e = sb.pop_front();
            if (e.tag == "ir") begin
                chk("ir", {32'd0, instr}, e.val);
                continue;
            end
            chk(e.tag, ctrl_now(), e.val);
            if (state == 3'd4) begin
                for (int unsigned i = 0; i < mem_waits; i++) begin
                    step();
                    chk("mem_hold", ctrl_now(), e.val);
                end
                mem_ready = 1'b1;
                step();
                mem_ready = 1'b0;
            end else begin
                step();
            end
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic reset_and_release();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int unsigned n;
        rst = 1'b1; start = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        repeat (3) step();
        chk("reset_outputs", all_outputs(), 64'd0);
        rst = 1'b0;
        step();
        chk("post_reset_fetch", {state, mem_req}, {3'd1, 1'b1});

        plan_wb(32'h00500093, 3'd0, 2'd0, 1'b1, 4'd0, 2'd0, 2'd0);
        issue(32'h00500093, 2, 0);

        alu_zero = 1'b1; plan_branch(32'h00208463, 1'b1); issue(32'h00208463, 0, 0);
        alu_zero = 1'b0; plan_branch(32'h00208463, 1'b0); issue(32'h00208463, 0, 0);
        alu_ltu = 1'b0;  plan_branch(32'h0020F463, 1'b1); issue(32'h0020F463, 0, 0);
        alu_ltu = 1'b1;  plan_branch(32'h0020F463, 1'b0); issue(32'h0020F463, 0, 0);
        alu_lt = 1'b1;   plan_branch(32'h0020C463, 1'b1); issue(32'h0020C463, 1, 0);
        alu_lt = 1'b0; alu_ltu = 1'b0;

        plan_wb(32'h40208033, 3'd0, 2'd0, 1'b0, 4'd1, 2'd0, 2'd0); issue(32'h40208033, 0, 0);
        plan_wb(32'h4020D033, 3'd0, 2'd0, 1'b0, 4'd7, 2'd0, 2'd0); issue(32'h4020D033, 0, 0);
        plan_wb(32'h4030D093, 3'd0, 2'd0, 1'b1, 4'd7, 2'd0, 2'd0); issue(32'h4030D093, 0, 0);
        plan_wb(32'h0020B033, 3'd0, 2'd0, 1'b0, 4'd9, 2'd0, 2'd0); issue(32'h0020B033, 0, 0);
        plan_wb(32'h0020F033, 3'd0, 2'd0, 1'b0, 4'd2, 2'd0, 2'd0); issue(32'h0020F033, 0, 0);
        plan_wb(32'h123450B7, 3'd3, 2'd2, 1'b1, 4'd0, 2'd0, 2'd0); issue(32'h123450B7, 0, 0);
        plan_wb(32'h00001097, 3'd3, 2'd1, 1'b1, 4'd0, 2'd0, 2'd0); issue(32'h00001097, 0, 0);
        plan_wb(32'h008000EF, 3'd4, 2'd0, 1'b0, 4'd0, 2'd1, 2'd2); issue(32'h008000EF, 0, 0);
        plan_wb(32'h000080E7, 3'd0, 2'd0, 1'b1, 4'd0, 2'd2, 2'd2); issue(32'h000080E7, 0, 0);

        plan_load(32'h0000A103); issue(32'h0000A103, 0, 3);
        plan_load(32'h0000A103); issue(32'h0000A103, 0, 15);

        push("ir", {32'd0, 32'h0020A023});
        push("sw_dec", cv(3'd1, 0, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        push("sw_exe", cv(3'd1, 0, 1, 4'd0, 1, 0, 0, 0, 0, 0, 0, 3'd3));
        push("sw_mem", cv(3'd1, 0, 1, 4'd0, 0, 0, 0, 0, 1, 1, 1, 3'd4));
        issue(32'h0020A023, 0, 0);
        chk("sw_back_to_fetch", state, 3'd1);

        push("ir", {32'd0, 32'h0020A023});
        push("swto_dec", cv(3'd1, 0, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        push("swto_exe", cv(3'd1, 0, 1, 4'd0, 1, 0, 0, 0, 0, 0, 0, 3'd3));
        issue(32'h0020A023, 0, 0);
        n = 0;
        while (state == 3'd4 && n < 40) begin
            n++;
            step();
        end
        chk("timeout_mem_cycles", 64'(n), 64'd16);
        chk("timeout_trap", {state, timeout_err, illegal_instr, mem_req}, {3'd6, 3'b100});
        mem_ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk("trap_hold", {state, mem_req, pc_write, ir_write, reg_write_en, timeout_err},
                {3'd6, 5'b00001});
        end
        mem_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("trap_reset", all_outputs(), 64'd0);
        rst = 1'b0;
        step();

        push("ir", {32'd0, 32'hFFFFFFFF});
        issue(32'hFFFFFFFF, 0, 0);
        chk("illegal_decode", {state, pc_write}, {3'd2, 1'b0});
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            chk("illegal_trap", {state, illegal_instr, timeout_err, pc_write, mem_req},
                {3'd6, 4'b1000});
        end
        reset_and_release();

        push("ir", {32'd0, 32'h40209033});
        issue(32'h40209033, 0, 0);
        step();
        chk("bad_funct7_trap", {state, illegal_instr, pc_write}, {3'd6, 2'b10});
        reset_and_release();

        push("ir", {32'd0, 32'h0000A103});
        push("lwr_dec", cv(3'd0, 0, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        push("lwr_exe", cv(3'd0, 0, 1, 4'd0, 1, 0, 0, 0, 0, 0, 0, 3'd3));
        issue(32'h0000A103, 0, 0);
        chk("pre_abort_mem", {state, mem_req}, {3'd4, 1'b1});
        rst = 1'b1;
        step();
        chk("abort_mem", {state, mem_req, addr_src}, {3'd0, 2'b00});
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
